// File: rtl/som_pkg.sv
// som_pkg: shared grid size, USS code points, learning-rate shifts and FSM states
package som_pkg;
    localparam int GRID = 8;
    localparam logic [1:0] SEL_WIN  = 2'b00;
    localparam logic [1:0] SEL_NEAR = 2'b01;
    localparam logic [1:0] SEL_FAR  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;
    localparam int SH_NEAR = 2;
    localparam int SH_FAR  = 3;
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_RD, S_CALC, S_WR, S_DONE} state_e;
endpackage

// File: rtl/som_lr_shift.sv
// som_lr_shift: one neuron component update, w' = w + ((x - w) >>> shift) selected by USS code
module som_lr_shift
    import som_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] x,
    input  logic [1:0]        code,
    output logic [DATA_W-1:0] w_new
);
    logic signed [DATA_W:0] diff, d_near, d_far;
    // The step always lands between w and x, so the modular sum truncates without overflow.
    always_comb begin
        diff   = $signed({1'b0, x}) - $signed({1'b0, w});
        d_near = diff >>> SH_NEAR;
        d_far  = diff >>> SH_FAR;
        w_new  = code == SEL_WIN  ? x :
                 code == SEL_NEAR ? DATA_W'({1'b0, w} + d_near) :
                 code == SEL_FAR  ? DATA_W'({1'b0, w} + d_far) : w;
    end
endmodule

// File: rtl/som_weight_update.sv
// som_weight_update: full-map SOM weight read-modify-write driven by USS neighbourhood codes.
// Define SKIP_FAR_EN to skip rows whose neighbourhood word is all SEL_NONE.
module som_weight_update
    import som_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIM    = 4,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              win_x,
    input  logic [2:0]              win_y,
    input  logic [DIM*DATA_W-1:0]   x_vec,
    output logic [2:0]              uss_xin,
    output logic [2:0]              uss_xc,
    output logic [2:0]              uss_yc,
    input  logic [2*GRID-1:0]       neighbor_sel,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [GRID*DATA_W-1:0]  rd_data,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [GRID*DATA_W-1:0]  wr_data,
    output logic                    busy,
    output logic                    done
);
    localparam int D_W = (DIM > 1) ? $clog2(DIM) : 1;

    state_e                  state_q, state_d;
    logic [2:0]              row_q, row_d, wx_q, wx_d, wy_q, wy_d;
    logic [D_W-1:0]          d_q, d_d;
    logic [DIM*DATA_W-1:0]   x_q, x_d;
    logic [2*GRID-1:0]       sel_q, sel_d;
    logic [GRID*DATA_W-1:0]  wr_data_q, wr_data_d, w_new;
    logic [ADDR_W-1:0]       addr;
    logic [DATA_W-1:0]       x_cur;
    logic                    last_row, last_d, accept;

    assign last_row = row_q == 3'(GRID - 1);
    assign last_d   = d_q == D_W'(DIM - 1);
    assign accept   = state_q == S_IDLE && start;
    assign addr     = ADDR_W'(row_q * DIM + d_q);
    assign x_cur    = x_q[d_q*DATA_W +: DATA_W];

    for (genvar c = 0; c < GRID; c++) begin : g_col
        // USS packs column 0 in the most significant code.
        som_lr_shift #(.DATA_W(DATA_W)) u_lr (
            .w     (rd_data[c*DATA_W +: DATA_W]),
            .x     (x_cur),
            .code  (sel_q[(GRID-1-c)*2 +: 2]),
            .w_new (w_new[c*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_SEL;
                row_d   = '0;
                d_d     = '0;
            end
            S_SEL: begin
                state_d = S_RD;
`ifdef SKIP_FAR_EN
                if (neighbor_sel == {GRID{SEL_NONE}}) begin
                    state_d = last_row ? S_DONE : S_SEL;
                    row_d   = last_row ? row_q : row_q + 3'd1;
                end
`endif
            end
            S_RD:   state_d = S_CALC;
            S_CALC: state_d = S_WR;
            S_WR: begin
                state_d = !last_d ? S_RD : !last_row ? S_SEL : S_DONE;
                d_d     = last_d ? '0 : d_q + D_W'(1);
                row_d   = last_d && !last_row ? row_q + 3'd1 : row_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wx_d      = accept ? win_x : wx_q;
        wy_d      = accept ? win_y : wy_q;
        x_d       = accept ? x_vec : x_q;
        sel_d     = state_q == S_SEL ? neighbor_sel : sel_q;
        wr_data_d = state_q == S_CALC ? w_new : wr_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q     <= '0;
            d_q       <= '0;
            wx_q      <= '0;
            wy_q      <= '0;
            x_q       <= '0;
            sel_q     <= '0;
            wr_data_q <= '0;
        end else begin
            row_q     <= row_d;
            d_q       <= d_d;
            wx_q      <= wx_d;
            wy_q      <= wy_d;
            x_q       <= x_d;
            sel_q     <= sel_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        rd_en   = state_q == S_RD;
        wr_en   = state_q == S_WR;
        done    = state_q == S_DONE;
        busy    = state_q inside {S_SEL, S_RD, S_CALC, S_WR};
        rd_addr = rd_en ? addr : '0;
        wr_addr = wr_en ? addr : '0;
        uss_xin = row_q;
        uss_xc  = wx_q;
        uss_yc  = wy_q;
        wr_data = wr_data_q;
    end
endmodule

// File: tb/tb_som_weight_update.sv
// tb_som_weight_update: directed checks of som_weight_update against a USS model and weight SRAM model.
module tb_som_weight_update;
    logic        clk = 0, rst = 0, start = 0;
    logic [2:0]  win_x = 0, win_y = 0;
    logic [31:0] x_vec = 0;
    logic [2:0]  uss_xin, uss_xc, uss_yc;
    logic [15:0] neighbor_sel;
    logic        rd_en, wr_en, busy, done;
    logic [4:0]  rd_addr, wr_addr;
    logic [63:0] rd_data = 0, wr_data;
    logic [63:0] mem [32];
    logic        fill = 0;
    logic [7:0]  fill_v = 0;
    int checks = 0, errors = 0;
    int dcyc, busy_cyc, overlap, redone, hit, idle_act;
    int rd_cnt [8];
    int wr_cnt [8];
    int exp_r3 [8] = '{100, 112, 125, 200, 125, 112, 100, 100};

    always #5 clk = ~clk;

    som_weight_update dut (
        .clk(clk), .rst(rst), .start(start), .win_x(win_x), .win_y(win_y), .x_vec(x_vec),
        .uss_xin(uss_xin), .uss_xc(uss_xc), .uss_yc(uss_yc), .neighbor_sel(neighbor_sel),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    // USS: Manhattan distance 0/1/2 -> WIN/NEAR/FAR, otherwise NONE
    function automatic logic [15:0] uss(input int xin, input int xc, input int yc);
        logic [15:0] s;
        int dst;
        for (int c = 0; c < 8; c++) begin
            dst = (xin > xc ? xin - xc : xc - xin) + (c > yc ? c - yc : yc - c);
            s[(7-c)*2 +: 2] = dst == 0 ? 2'b00 : dst == 1 ? 2'b01 : dst == 2 ? 2'b10 : 2'b11;
        end
        return s;
    endfunction

    assign neighbor_sel = uss(int'(uss_xin), int'(uss_xc), int'(uss_yc));

    always @(posedge clk) begin
        if (fill) for (int i = 0; i < 32; i++) mem[i] <= {8{fill_v}};
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    function automatic int wt(input int r, input int d, input int c);
        logic [63:0] v;
        v = mem[r*4 + d];
        return int'(v[c*8 +: 8]);
    endfunction

    function automatic bit far_row(input int r, input int wx, input int wy);
`ifdef SKIP_FAR_EN
        return uss(r, wx, wy) == 16'hFFFF;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_done(input int wx, input int wy);
        int t = 1;
        for (int r = 0; r < 8; r++) t += far_row(r, wx, wy) ? 1 : 13;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input int v);
        @(negedge clk);
        fill_v = 8'(v);
        fill = 1;
        @(negedge clk);
        fill = 0;
    endtask

    task automatic begin_op(input int wx, input int wy, input int xv);
        @(negedge clk);
        win_x = 3'(wx);
        win_y = 3'(wy);
        for (int d = 0; d < 4; d++) x_vec[d*8 +: 8] = 8'(xv);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // Cycle 0 holds start; counting begins at cycle 1, the first cycle after acceptance.
    task automatic run(input int wx, input int wy, input int xv, input int restart_at);
        int n = 1;
        dcyc = -1; busy_cyc = 0; overlap = 0; redone = 0;
        for (int r = 0; r < 8; r++) begin rd_cnt[r] = 0; wr_cnt[r] = 0; end
        begin_op(wx, wy, xv);
        chk("xc_latched", 32'(uss_xc), 32'(wx));
        chk("yc_latched", 32'(uss_yc), 32'(wy));
        chk("busy_c1", 32'(busy), 1);
        while (n < 400) begin
            if (done) begin dcyc = n; break; end
            busy_cyc += int'(busy);
            overlap += int'(rd_en && wr_en);
            if (rd_en) rd_cnt[int'(rd_addr) / 4]++;
            if (wr_en) wr_cnt[int'(wr_addr) / 4]++;
            start = n == restart_at;
            @(negedge clk);
            n++;
        end
        start = 0;
        chk("done_cycle", 32'(dcyc), 32'(exp_done(wx, wy)));
        chk("busy_at_done", 32'(busy), 0);
        chk("busy_cycles", 32'(busy_cyc), 32'(exp_done(wx, wy) - 1));
        chk("rd_wr_excl", 32'(overlap), 0);
        repeat (4) begin
            @(negedge clk);
            redone += int'(done || busy);
        end
        chk("idle_after", 32'(redone), 0);
    endtask

    initial begin
        #1;
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_data", 32'(wr_data != 0), 0);
        chk("rst_xc", 32'(uss_xc), 0);
        repeat (2) @(negedge clk);
        rst = 1;

        fill_mem(100);
        run(3, 3, 200, 50);
        for (int c = 0; c < 8; c++) chk($sformatf("r3c%0d", c), 32'(wt(3, 0, c)), 32'(exp_r3[c]));
        chk("r3d3c3", 32'(wt(3, 3, 3)), 200);
        chk("r2c3", 32'(wt(2, 1, 3)), 125);
        for (int c = 0; c < 8; c++) chk($sformatf("r0c%0d", c), 32'(wt(0, 2, c)), 100);

        fill_mem(100);
        run(0, 0, 0, -1);
        chk("neg_sel00", 32'(wt(0, 0, 0)), 0);
        chk("neg_sel01", 32'(wt(0, 0, 1)), 75);
        chk("neg_sel10", 32'(wt(0, 0, 2)), 87);
        chk("neg_r1c1", 32'(wt(1, 3, 1)), 87);
        chk("far_r5_rd", 32'(rd_cnt[5]), far_row(5, 0, 0) ? 0 : 4);
        chk("far_r7_wr", 32'(wr_cnt[7]), far_row(7, 0, 0) ? 0 : 4);
        chk("far_r5_val", 32'(wt(5, 2, 4)), 100);

        fill_mem(50);
        run(7, 7, 10, -1);
        chk("edge_r7c7", 32'(wt(7, 0, 7)), 10);
        chk("edge_r7c6", 32'(wt(7, 0, 6)), 40);
        chk("edge_r7c5", 32'(wt(7, 0, 5)), 45);
        chk("edge_r6c7", 32'(wt(6, 3, 7)), 40);
        chk("edge_r4c7", 32'(wt(4, 0, 7)), 50);
        chk("edge_r0c0", 32'(wt(0, 0, 0)), 50);

        fill_mem(100);
        begin_op(3, 3, 200);
        hit = 0;
        for (int n = 0; n < 400 && hit == 0; n++) begin
            if (wr_en && wr_addr == 5'd16) hit = 1;
            else @(negedge clk);
        end
        chk("rst_hit_r4_wr", 32'(hit), 1);
        rst = 0;
        #1;
        chk("abort_wr_en", 32'(wr_en), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        rst = 1;
        idle_act = 0;
        repeat (4) begin
            @(negedge clk);
            idle_act += int'(rd_en || wr_en || busy || done);
        end
        chk("abort_idle", 32'(idle_act), 0);
        run(3, 3, 200, -1);
        chk("fresh_r3c3", 32'(wt(3, 0, 3)), 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
